alu_ctrl_mul_seq: RTL and testbench
===================================

Name: alu_ctrl_mul_seq

Overview:
- Consumes the 6-bit code chosen by the upstream func/op select and turns it into the 4-bit ALU control word for the datapath ALU.
- Adds a sequential 32-iteration shift-add multiplier for MULT/MULTU, with HI/LO registers.
- Raises stall so the PC and instruction hold while a multiply runs.
- Ordinary instructions still decode combinationally and complete in a single cycle.

Parameters:
- DATA_W, 32, operand width; HI/LO are each DATA_W wide.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- code  in  6  selected code (funct when code_is_op=0, opcode when code_is_op=1)
- code_is_op  in  1  same select that drove the upstream mux
- instr_valid  in  1  instruction on code/operands is live this cycle
- rs_val  in  DATA_W  multiplicand
- rt_val  in  DATA_W  multiplier
- alu_ctrl  out  4  ALU control word
- stall  out  1  hold PC/IR this cycle
- mul_busy  out  1  FSM in RUN
- mul_done  out  1  one-cycle pulse; HI/LO just updated
- hi  out  DATA_W  product upper half
- lo  out  DATA_W  product lower half

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, hi=0, lo=0, stall=0, mul_busy=0, mul_done=0.
  - alu_ctrl is combinational; it shows NOP until valid code is driven.
- Decode is combinational, zero latency, independent of FSM state.
- R-type decode (code_is_op=0):
  - 0x20 ADD -> 0010; 0x22 SUB -> 0110; 0x24 AND -> 0000; 0x25 OR -> 0001
  - 0x27 NOR -> 1100; 0x2A SLT -> 0111; 0x00 SLL -> 1000; 0x02 SRL -> 1001
  - 0x18 MULT, 0x19 MULTU, 0x10 MFHI, 0x12 MFLO -> 1111 (NOP)
- I-type decode (code_is_op=1):
  - 0x08 ADDI, 0x23 LW, 0x2B SW -> 0010; 0x0C ANDI -> 0000; 0x0D ORI -> 0001
  - 0x0A SLTI -> 0111; 0x04 BEQ -> 0110
- Any other code -> 1111.
- start = instr_valid & ~code_is_op & (code==0x18 | code==0x19) & state==IDLE.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN on start. In the same edge, latch |rs|, |rt| (abs only for MULT), the sign flag (rs[31]^rt[31], MULT only), and the signed/unsigned flag. Clear the 2*DATA_W accumulator; counter=0.
  - RUN: each cycle, if multiplier LSB=1 add multiplicand to the accumulator upper half; shift accumulator and multiplier right 1; counter++.
  - RUN -> DONE after DATA_W RUN cycles (counter==DATA_W-1 on the transition edge). On that same edge, write the product to {hi,lo}, two's-complement-negated over 64 bits if the sign flag is set.
  - DONE -> IDLE unconditionally. start is never evaluated in DONE, so the still-presented MULT does not restart.
- stall = start | (state==RUN). For one multiply, stall is high for exactly 1+DATA_W = 33 consecutive cycles, then low in DONE.
- mul_busy = (state==RUN). mul_done = (state==DONE).
- hi/lo change only on the DONE-entry edge or reset. MFHI/MFLO during IDLE read the last result.
- instr_valid or code changing during RUN is ignored; the operation completes.
- Reset mid-RUN aborts: IDLE and hi=lo=0 immediately; no mul_done pulse.
- Boundary cases:
  - Signed 0x80000000 operands: the abs value is 2^31, which fits the unsigned DATA_W register.
  - Zero operand: runs all 33 cycles; no early exit.

Decomposition:
- Package alu_ctrl_pkg holds:
  - funct/opcode localparams (F_ADD, F_MULT, OP_LW, ...)
  - ALU control encodings (ALU_AND=4'b0000 ... ALU_NOP=4'b1111)
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
- One sub-module, mul_shift_add_core: accumulator, multiplier shift register, counter, sign fix-up.
- The top level keeps the decode, FSM, stall logic, and HI/LO registers.

Test Plan:
- Decode sweep: code_is_op=0, code=0x22 -> alu_ctrl=0110. code_is_op=1, code=0x22 -> 1111. code_is_op=1, 0x23 -> 0010. code_is_op=0, 0x2A -> 0111. All with stall=0.
- MULT 7 x -3 (rs=0x00000007, rt=0xFFFFFFFD): stall high 33 cycles, mul_done pulse in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT same operands (-1 x -1) -> hi=0, lo=1.
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0 x 0x12345678 -> hi=lo=0 after full 33-cycle stall.
- Reset asserted asynchronously at RUN cycle 10: stall, mul_busy, hi, lo drop to 0 without waiting for clk. After release, code=0x18 held with instr_valid=1 restarts a fresh 33-cycle stall.
- MULT held on inputs through DONE: exactly one mul_done pulse. A back-to-back second MULT (code=0x19 next IDLE cycle) starts cleanly; the prior hi/lo stay visible until its DONE-entry edge.

Source files
------------

// File: rtl/alu_ctrl_mul_seq_pkg.sv
// Shared encodings for the ALU control decoder and the sequential multiplier:
// funct/opcode values, ALU control words, FSM states and the decode function.
package alu_ctrl_pkg;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic logic [3:0] decode_alu(input logic [5:0] code, input logic is_op);
        logic [3:0] ctrl;
        ctrl = ALU_NOP;
        if (!is_op) begin
            case (code)
                F_ADD:   ctrl = ALU_ADD;
                F_SUB:   ctrl = ALU_SUB;
                F_AND:   ctrl = ALU_AND;
                F_OR:    ctrl = ALU_OR;
                F_NOR:   ctrl = ALU_NOR;
                F_SLT:   ctrl = ALU_SLT;
                F_SLL:   ctrl = ALU_SLL;
                F_SRL:   ctrl = ALU_SRL;
                F_MULT, F_MULTU, F_MFHI, F_MFLO: ctrl = ALU_NOP;
                default: ctrl = ALU_NOP;
            endcase
        end else begin
            case (code)
                OP_ADDI, OP_LW, OP_SW: ctrl = ALU_ADD;
                OP_ANDI: ctrl = ALU_AND;
                OP_ORI:  ctrl = ALU_OR;
                OP_SLTI: ctrl = ALU_SLT;
                OP_BEQ:  ctrl = ALU_SUB;
                default: ctrl = ALU_NOP;
            endcase
        end
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_ctrl_mul_seq_if.sv
// Instruction/operand inputs and control/result outputs of the ALU control + multiplier block.
interface alu_ctrl_mul_seq_if #(
    parameter int DATA_W = 32
);
    logic [5:0]        code;
    logic              code_is_op;
    logic              instr_valid;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [3:0]        alu_ctrl;
    logic              stall;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output code, code_is_op, instr_valid, rs_val, rt_val,
        input  alu_ctrl, stall, mul_busy, mul_done, hi, lo
    );

    modport slave (
        input  code, code_is_op, instr_valid, rs_val, rt_val,
        output alu_ctrl, stall, mul_busy, mul_done, hi, lo
    );
endinterface

// File: rtl/alu_ctrl_mul_seq_mul_shift_add_core.sv
// Shift-add multiplier datapath: magnitude operands, 2*DATA_W accumulator, iteration
// counter and final sign fix-up. Sequencing comes from the parent FSM via load/step.
module mul_shift_add_core #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  is_signed,
    input  logic [DATA_W-1:0]     rs_val,
    input  logic [DATA_W-1:0]     rt_val,
    output logic                  last_step,
    output logic [2*DATA_W-1:0]   product_next
);
    logic [DATA_W-1:0]   mcand_reg;
    logic [DATA_W-1:0]   mplier_reg;
    logic [2*DATA_W-1:0] acc_reg;
    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W:0]     upper_sum;
    logic [CNT_W-1:0]    cnt_reg;
    logic                neg_reg;

    // One extra bit on the upper-half sum keeps the carry, which the shift pulls back in.
    always_comb begin
        upper_sum    = {1'b0, acc_reg[2*DATA_W-1:DATA_W]}
                     + (mplier_reg[0] ? {1'b0, mcand_reg} : {(DATA_W+1){1'b0}});
        acc_next     = {upper_sum, acc_reg[DATA_W-1:1]};
        product_next = neg_reg ? (~acc_next + 1'b1) : acc_next;
    end

    assign last_step = (cnt_reg == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
        end else if (load) begin
            // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
            mcand_reg  <= (is_signed && rs_val[DATA_W-1]) ? (~rs_val + 1'b1) : rs_val;
            mplier_reg <= (is_signed && rt_val[DATA_W-1]) ? (~rt_val + 1'b1) : rt_val;
            neg_reg    <= is_signed && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (step) begin
            acc_reg    <= acc_next;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/alu_ctrl_mul_seq.sv
// ALU control decoder with a 32-iteration sequential MULT/MULTU unit, HI/LO
// registers and a pipeline stall while a multiply is in flight.
module alu_ctrl_mul_seq
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic               clk,
    input  logic               reset,
    alu_ctrl_mul_seq_if.slave  bus
);
    mul_state_t          state_reg;
    logic [DATA_W-1:0]   hi_reg;
    logic [DATA_W-1:0]   lo_reg;
    logic                mul_busy_reg;
    logic                mul_done_reg;
    logic                start;
    logic                is_mult;
    logic                last_step;
    logic [2*DATA_W-1:0] product_next;

    assign bus.alu_ctrl = decode_alu(bus.code, bus.code_is_op);

    assign is_mult = (bus.code == F_MULT);
    // Gated by reset so a MULT held on the inputs does not assert stall during reset.
    assign start = bus.instr_valid && !bus.code_is_op
                && (bus.code == F_MULT || bus.code == F_MULTU)
                && (state_reg == IDLE) && !reset;

    assign bus.stall    = start || (state_reg == RUN);
    assign bus.mul_busy = mul_busy_reg;
    assign bus.mul_done = mul_done_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;

    mul_shift_add_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .load         (start),
        .step         (state_reg == RUN),
        .is_signed    (is_mult),
        .rs_val       (bus.rs_val),
        .rt_val       (bus.rt_val),
        .last_step    (last_step),
        .product_next (product_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            hi_reg       <= '0;
            lo_reg       <= '0;
            mul_busy_reg <= 1'b0;
            mul_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    mul_done_reg <= 1'b0;
                    if (start) begin
                        state_reg    <= RUN;
                        mul_busy_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_step) begin
                        state_reg        <= DONE;
                        mul_busy_reg     <= 1'b0;
                        mul_done_reg     <= 1'b1;
                        {hi_reg, lo_reg} <= product_next;
                    end
                end
                DONE: begin
                    // start is not evaluated here, so a still-held MULT cannot re-trigger.
                    state_reg    <= IDLE;
                    mul_done_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    mul_busy_reg <= 1'b0;
                    mul_done_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl_mul_seq.sv
// Directed bench for alu_ctrl_mul_seq: decode vectors, multiply results and stall timing, async reset abort.
module tb_alu_ctrl_mul_seq;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    alu_ctrl_mul_seq_if #(.DATA_W(32)) bus ();

    alu_ctrl_mul_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_dec(input logic is_op, input logic [5:0] code, input logic [3:0] exp);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.code_is_op  = is_op;
        bus.code        = code;
        #1;
        $display("decode is_op=%0d code=0x%02h alu_ctrl=%04b stall=%0d", is_op, code, bus.alu_ctrl, bus.stall);
        check_val("alu_ctrl", 64'(bus.alu_ctrl), 64'(exp));
        check_val("dec_stall", 64'(bus.stall), 64'd0);
    endtask

    // Inputs must already be presenting the multiply for the current cycle (driven just after posedge).
    task automatic measure_mul(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int stall_cnt;
        int early_done;
        stall_cnt  = 0;
        early_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.stall) break;
            stall_cnt++;
            if (bus.mul_done) early_done++;
            if (i == 1) begin
                check_val("busy_in_run", 64'(bus.mul_busy), 64'd1);
                check_val("hi_held", 64'(bus.hi), 64'(last_hi));
                check_val("lo_held", 64'(bus.lo), 64'(last_lo));
            end
        end
        $display("%s: stall_cycles=%0d hi=0x%08h lo=0x%08h done=%0d", tag, stall_cnt, bus.hi, bus.lo, bus.mul_done);
        check_val("stall_len", 64'(stall_cnt), 64'd33);
        check_val("early_done", 64'(early_done), 64'd0);
        check_val("mul_done", 64'(bus.mul_done), 64'd1);
        check_val("busy_done", 64'(bus.mul_busy), 64'd0);
        check_val("hi", 64'(bus.hi), 64'(exp_hi));
        check_val("lo", 64'(bus.lo), 64'(exp_lo));
        last_hi = exp_hi;
        last_lo = exp_lo;
        @(posedge clk);
        #1;
    endtask

    task automatic do_mul(input string tag, input logic [5:0] code,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        bus.instr_valid = 1'b1;
        bus.code_is_op  = 1'b0;
        bus.code        = code;
        bus.rs_val      = rs;
        bus.rt_val      = rt;
        measure_mul(tag, exp_hi, exp_lo);
    endtask

    // Drops the multiply after DONE and confirms no second pulse or restart follows.
    task automatic go_idle();
        bus.instr_valid = 1'b0;
        bus.code        = 6'h20;
        @(negedge clk);
        check_val("done_single", 64'(bus.mul_done), 64'd0);
        check_val("idle_stall", 64'(bus.stall), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_hi  = '0;
        last_lo  = '0;
        reset           = 1'b1;
        bus.code        = 6'h3F;
        bus.code_is_op  = 1'b0;
        bus.instr_valid = 1'b0;
        bus.rs_val      = '0;
        bus.rt_val      = '0;
        #12;
        check_val("rst_stall", 64'(bus.stall), 64'd0);
        check_val("rst_busy", 64'(bus.mul_busy), 64'd0);
        check_val("rst_done", 64'(bus.mul_done), 64'd0);
        check_val("rst_hi", 64'(bus.hi), 64'd0);
        check_val("rst_lo", 64'(bus.lo), 64'd0);
        check_val("rst_alu_nop", 64'(bus.alu_ctrl), 64'hF);
        @(posedge clk);
        #1;
        reset = 1'b0;

        check_dec(1'b0, 6'h22, 4'b0110);
        check_dec(1'b1, 6'h22, 4'b1111);
        check_dec(1'b1, 6'h23, 4'b0010);
        check_dec(1'b0, 6'h2A, 4'b0111);
        check_dec(1'b0, 6'h27, 4'b1100);
        check_dec(1'b0, 6'h02, 4'b1001);
        check_dec(1'b1, 6'h04, 4'b0110);
        check_dec(1'b1, 6'h18, 4'b1111);
        check_dec(1'b0, 6'h10, 4'b1111);
        bus.instr_valid = 1'b0;
        @(posedge clk);
        #1;

        do_mul("mult_0_x", 6'h18, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
        go_idle();
        @(posedge clk);
        #1;
        do_mul("mult_7_m3", 6'h18, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        go_idle();
        @(posedge clk);
        #1;
        do_mul("multu_ff", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        go_idle();
        @(posedge clk);
        #1;
        do_mul("mult_m1_m1", 6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        go_idle();
        @(posedge clk);
        #1;
        // MULT held through DONE, then MULTU presented in the very next IDLE cycle.
        do_mul("mult_min_min", 6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        do_mul("multu_b2b", 6'h19, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        go_idle();
        @(posedge clk);
        #1;

        bus.instr_valid = 1'b1;
        bus.code_is_op  = 1'b0;
        bus.code        = 6'h18;
        bus.rs_val      = 32'h0000_0007;
        bus.rt_val      = 32'hFFFF_FFFD;
        repeat (10) @(negedge clk);
        check_val("busy_pre_rst", 64'(bus.mul_busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        $display("async reset mid-run: stall=%0d busy=%0d hi=0x%08h lo=0x%08h", bus.stall, bus.mul_busy, bus.hi, bus.lo);
        check_val("arst_stall", 64'(bus.stall), 64'd0);
        check_val("arst_busy", 64'(bus.mul_busy), 64'd0);
        check_val("arst_done", 64'(bus.mul_done), 64'd0);
        check_val("arst_hi", 64'(bus.hi), 64'd0);
        check_val("arst_lo", 64'(bus.lo), 64'd0);
        last_hi = '0;
        last_lo = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        measure_mul("mult_after_rst", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        go_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
